// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control / trace slice.
package cpu_dbg_pkg;

  localparam logic [1:0] ST_RST_HOLD = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  localparam logic [1:0] HC_NONE   = 2'd0;
  localparam logic [1:0] HC_BUDGET = 2'd1;
  localparam logic [1:0] HC_BP     = 2'd2;
  localparam logic [1:0] HC_STEP   = 2'd3;

  localparam logic [1:0] MODE_FREE = 2'd0;
  localparam logic [1:0] MODE_STEP = 2'd1;
  localparam logic [1:0] MODE_BP   = 2'd2;

  // The reserved mode code behaves as free-run.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_FREE : m;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Overwrite-on-full FWFT FIFO holding the most recent executed PCs.
module trace_fifo #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [PC_W-1:0] push_data,
  input  logic            pop,
  output logic [PC_W-1:0] rd_data,
  output logic            valid,
  output logic            ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A push into a full buffer discards the oldest entry, so the read side moves too.
      if (do_pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !do_pop) ovf <= 1'b1;
      if (push && !do_pop && !full) count <= count + 1'b1;
      else if (do_pop && !push)     count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU reset sequencing, run/step/breakpoint control with cycle budget, and PC trace.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CYC_W       = 16,
  parameter int RST_CYCLES  = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int NUM_BP      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   step,
  input  logic [CYC_W-1:0]       run_max,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [PC_W-1:0]        cpu_pc,
  output logic                   cpu_rst,
  output logic                   cpu_en,
  output logic [1:0]             state,
  output logic [1:0]             halt_cause,
  output logic [CYC_W-1:0]       cycle_cnt,
  input  logic                   trace_rd,
  output logic [PC_W-1:0]        trace_data,
  output logic                   trace_valid,
  output logic                   trace_ovf
);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [RCW-1:0]    rst_cnt;
  logic [1:0]        mode_q;
  logic              resume_q;
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit, budget_hit, go_idle, go_halt;
  logic [CYC_W-1:0]  cnt_inc;

  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == cpu_pc);
  end

  // The resume flag lets the instruction parked on a breakpoint execute once.
  assign bp_hit     = (state == ST_RUN) && (mode_q == MODE_BP) && (|bp_match) && !resume_q;
  assign cpu_en     = (state == ST_RUN) && !bp_hit;
  assign cpu_rst    = (state == ST_RST_HOLD);
  assign cnt_inc    = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
  assign budget_hit = (run_max != '0) && (cnt_inc == run_max);
  assign go_idle    = (norm_mode(mode) == MODE_STEP) ? (start || step) : start;
  assign go_halt    = start || (step && (mode_q == MODE_STEP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST_HOLD;
      rst_cnt    <= '0;
      halt_cause <= HC_NONE;
      cycle_cnt  <= '0;
      mode_q     <= MODE_FREE;
      resume_q   <= 1'b0;
    end else begin
      case (state)
        ST_RST_HOLD: begin
          if (rst_cnt == RCW'(RST_CYCLES-1)) state <= ST_IDLE;
          else                               rst_cnt <= rst_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (go_idle) begin
            state      <= ST_RUN;
            cycle_cnt  <= '0;
            halt_cause <= HC_NONE;
            mode_q     <= norm_mode(mode);
            resume_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          resume_q <= 1'b0;
          if (bp_hit) begin
            state      <= ST_HALT;
            halt_cause <= HC_BP;
          end else begin
            cycle_cnt <= cnt_inc;
            if (budget_hit) begin
              state      <= ST_HALT;
              halt_cause <= HC_BUDGET;
            end else if (mode_q == MODE_STEP) begin
              state      <= ST_HALT;
              halt_cause <= HC_STEP;
            end
          end
        end
        default: begin
          if (go_halt) begin
            state      <= ST_RUN;
            halt_cause <= HC_NONE;
            // An exhausted budget starts afresh; other halts keep counting.
            if (halt_cause == HC_BUDGET) cycle_cnt <= '0;
            mode_q     <= norm_mode(mode);
            resume_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  trace_fifo #(.PC_W(PC_W), .DEPTH(TRACE_DEPTH)) u_trace (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_en),
    .push_data (cpu_pc),
    .pop       (trace_rd),
    .rd_data   (trace_data),
    .valid     (trace_valid),
    .ovf       (trace_ovf)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench: a tiny CPU model advances the PC on cpu_en; expected trace PCs are queued and drained.
module tb_cpu_run_ctrl;
  localparam int PC_W = 32, CYC_W = 16, RST_CYCLES = 4, TRACE_DEPTH = 16, NUM_BP = 2;

  logic                   clk = 1'b0, rst = 1'b1;
  logic [1:0]             mode = 2'd0;
  logic                   start = 1'b0, step = 1'b0, trace_rd = 1'b0;
  logic [CYC_W-1:0]       run_max = '0;
  logic [NUM_BP*PC_W-1:0] bp_addr = '0;
  logic [NUM_BP-1:0]      bp_en = '0;
  logic [PC_W-1:0]        cpu_pc = '0;
  logic                   cpu_rst, cpu_en, trace_valid, trace_ovf;
  logic [1:0]             state, halt_cause;
  logic [CYC_W-1:0]       cycle_cnt;
  logic [PC_W-1:0]        trace_data;

  int n_chk = 0, n_pass = 0, en_cnt = 0, en0;
  logic [31:0] exp_q [$];

  cpu_run_ctrl #(.PC_W(PC_W), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES),
                 .TRACE_DEPTH(TRACE_DEPTH), .NUM_BP(NUM_BP)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .step(step), .run_max(run_max),
    .bp_addr(bp_addr), .bp_en(bp_en), .cpu_pc(cpu_pc), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
    .state(state), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .trace_rd(trace_rd),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_ovf(trace_ovf));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_rst === 1'b1)     cpu_pc <= '0;
    else if (cpu_en === 1'b1) cpu_pc <= cpu_pc + 32'd4;
    if (cpu_en === 1'b1) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // All tasks enter and leave at a falling edge.
  task automatic do_reset(input bit full);
    rst = 1'b1; start = 1'b0; step = 1'b0; trace_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < RST_CYCLES; k++) begin
      chk("rst_hold_cpu_rst", 32'(cpu_rst), 32'd1);
      @(negedge clk);
    end
    chk("rst_idle_state", 32'(state), 32'd1);
    chk("rst_idle_cpu_rst", 32'(cpu_rst), 32'd0);
    if (full) begin
      chk("rst_cpu_en", 32'(cpu_en), 32'd0);
      chk("rst_cause", 32'(halt_cause), 32'd0);
      chk("rst_cnt", 32'(cycle_cnt), 32'd0);
      chk("rst_tvalid", 32'(trace_valid), 32'd0);
      chk("rst_tovf", 32'(trace_ovf), 32'd0);
      chk("rst_tdata", trace_data, 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max, input bit bp_watch);
    for (int i = 0; i < max; i++) begin
      if (state == 2'd3) break;
      if (bp_watch && state == 2'd2 && cpu_pc == 32'h20) chk("bp_cpu_en_low", 32'(cpu_en), 32'd0);
      @(negedge clk);
    end
    chk(tag, 32'(state), 32'd3);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      chk("trace_valid", 32'(trace_valid), 32'd1);
      chk("trace_data", trace_data, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hdead_beef);
      trace_rd = 1'b1;
      @(negedge clk);
      trace_rd = 1'b0;
    end
    chk("trace_empty", 32'(trace_valid), 32'd0);
  endtask

  task automatic step_once();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_run", 32'(state), 32'd2);
    chk("step_en", 32'(cpu_en), 32'd1);
    @(negedge clk);
    chk("step_halt", 32'(state), 32'd3);
    chk("step_cause", 32'(halt_cause), 32'd3);
  endtask

  initial begin
    do_reset(1'b1);

    // free-run with a 10-cycle budget
    mode = 2'd0; run_max = 16'd10;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i*4));
    en0 = en_cnt;
    pulse_start();
    wait_halt("a_halt", 40, 1'b0);
    chk("a_cause", 32'(halt_cause), 32'd1);
    chk("a_cnt", 32'(cycle_cnt), 32'd10);
    chk("a_en_cycles", 32'(en_cnt - en0), 32'd10);
    chk("a_ovf", 32'(trace_ovf), 32'd0);
    drain(10);

    // run to breakpoint at 0x20, then resume past it
    do_reset(1'b0);
    mode = 2'd2; run_max = '0; bp_addr = {32'h0, 32'h20}; bp_en = 2'b01;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i*4));
    pulse_start();
    wait_halt("b_halt", 40, 1'b1);
    chk("b_cause", 32'(halt_cause), 32'd2);
    chk("b_pc", cpu_pc, 32'h20);
    chk("b_cnt", 32'(cycle_cnt), 32'd8);
    chk("b_halt_en", 32'(cpu_en), 32'd0);
    drain(8);
    pulse_start();
    chk("b_res_state", 32'(state), 32'd2);
    chk("b_res_en", 32'(cpu_en), 32'd1);
    chk("b_res_pc", cpu_pc, 32'h20);
    repeat (3) @(negedge clk);
    chk("b_cont_state", 32'(state), 32'd2);
    chk("b_cont_pc", cpu_pc, 32'h2c);
    chk("b_cont_cnt", 32'(cycle_cnt), 32'd11);

    // single-step three times
    do_reset(1'b0);
    mode = 2'd1; bp_en = '0;
    repeat (3) step_once();
    chk("c_cnt", 32'(cycle_cnt), 32'd3);
    chk("c_pc", cpu_pc, 32'hc);

    // 20 pushes into a 16-deep trace
    do_reset(1'b0);
    mode = 2'd0; run_max = 16'd20;
    for (int i = 4; i < 20; i++) exp_q.push_back(32'(i*4));
    pulse_start();
    wait_halt("d1_halt", 60, 1'b0);
    chk("d1_cnt", 32'(cycle_cnt), 32'd20);
    chk("d1_ovf", 32'(trace_ovf), 32'd1);
    drain(16);

    // fill exactly, then push+pop at full for 4 cycles
    do_reset(1'b0);
    run_max = 16'd16;
    for (int i = 4; i < 20; i++) exp_q.push_back(32'(i*4));
    pulse_start();
    wait_halt("d2_halt", 60, 1'b0);
    chk("d2_full_ovf", 32'(trace_ovf), 32'd0);
    run_max = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; trace_rd = 1'b1;
    repeat (4) @(negedge clk);
    trace_rd = 1'b0;
    chk("d2_halt2", 32'(state), 32'd3);
    chk("d2_cnt", 32'(cycle_cnt), 32'd4);
    chk("d2_ovf", 32'(trace_ovf), 32'd0);
    drain(16);

    // reset in the middle of a run
    do_reset(1'b0);
    run_max = '0;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (cycle_cnt == 16'd7) break;
      @(negedge clk);
    end
    chk("e_cnt7", 32'(cycle_cnt), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    chk("e_state", 32'(state), 32'd0);
    chk("e_cpu_en", 32'(cpu_en), 32'd0);
    chk("e_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("e_cnt", 32'(cycle_cnt), 32'd0);
    chk("e_tvalid", 32'(trace_valid), 32'd0);
    chk("e_cause", 32'(halt_cause), 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run-control and trace block between the system clock/reset and the CPU core. It sequences CPU reset and gates execution with a clock-enable. Execution can be free-run, single-step, or run-to-breakpoint, with a cycle budget. The last `TRACE_DEPTH` executed PCs are kept in a readable trace buffer.

## Interface
Parameters:
- `PC_W`, 32: CPU program-counter width.
- `CYC_W`, 16: cycle counter / budget width.
- `RST_CYCLES`, 4: CPU reset hold length in cycles, ≥1.
- `TRACE_DEPTH`, 16: trace entries, power of two, ≥2.
- `NUM_BP`, 2: breakpoint comparators, ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  0 free-run, 1 single-step, 2 run-to-breakpoint, 3 reserved (treated as 0).
- `start`  in  1  one-cycle pulse: begin or resume execution.
- `step`  in  1  one-cycle pulse: execute one instruction (mode 1).
- `run_max`  in  `CYC_W`  cycle budget; 0 = unlimited.
- `bp_addr`  in  `NUM_BP*PC_W`  breakpoint PCs, entry i at `[i*PC_W +: PC_W]`.
- `bp_en`  in  `NUM_BP`  per-breakpoint enable.
- `cpu_pc`  in  `PC_W`  current CPU PC.
- `cpu_rst`  out  1  reset to CPU core.
- `cpu_en`  out  1  CPU advance enable (combinational).
- `state`  out  2  0 RST_HOLD, 1 IDLE, 2 RUN, 3 HALT.
- `halt_cause`  out  2  0 none, 1 budget, 2 breakpoint, 3 step.
- `cycle_cnt`  out  `CYC_W`  enabled cycles since the last clear; saturates at all-ones.
- `trace_rd`  in  1  pop oldest trace entry.
- `trace_data`  out  `PC_W`  oldest trace entry; valid when `trace_valid`.
- `trace_valid`  out  1  trace buffer non-empty.
- `trace_ovf`  out  1  sticky: an entry was overwritten.

## Operation
- Reset values:
  - `state` = RST_HOLD, `cpu_rst` = 1, `cpu_en` = 0, `halt_cause` = 0, `cycle_cnt` = 0.
  - Trace buffer empty, `trace_valid` = 0, `trace_ovf` = 0, `trace_data` = 0.
- RST_HOLD: `cpu_rst` = 1 for exactly `RST_CYCLES` cycles after `rst` falls, then → IDLE. `start`/`step` ignored.
- IDLE:
  - In mode 0/2, `start` → RUN.
  - In mode 1, `start` or `step` → RUN.
  - Each such entry clears `cycle_cnt` and `halt_cause` and latches `mode` into `mode_q`.
- RUN:
  - `cpu_en` = 1 unless a breakpoint hit is active this cycle.
  - Each cycle with `cpu_en` = 1: `cycle_cnt` += 1 and `cpu_pc` is pushed to the trace.
- Exit from RUN, priority order:
  - Breakpoint hit: `mode_q` = 2, some `bp_en[i]` set with `bp_addr[i]` == `cpu_pc`, and not the first RUN cycle after a resume. `cpu_en` = 0 that cycle, the instruction is not executed. → HALT, cause 2.
  - Budget: `run_max` ≠ 0 and the incremented `cycle_cnt` == `run_max`. → HALT, cause 1.
  - Step: `mode_q` = 1, after one enabled cycle. → HALT, cause 3.
- HALT:
  - `cpu_en` = 0.
  - `start` (or `step` when `mode_q` = 1) → RUN and clears `halt_cause`.
  - `cycle_cnt` is cleared only if the previous cause was 1, otherwise preserved.
  - `mode` is re-latched.
  - Breakpoint suppression applies to the first RUN cycle after every HALT→RUN.
- Trace buffer:
  - Circular, `TRACE_DEPTH` entries, first-word-fall-through.
  - Push when full overwrites the oldest entry and sets `trace_ovf`.
  - Pop when empty is ignored.
  - Push and pop in the same cycle: count unchanged; if full, the oldest is popped and the new entry is appended with no overflow.
- `rst` at any time, including mid-RUN, returns to RST_HOLD with all reset values in the next cycle.

## Timing
- `cpu_en` is combinational from the registered state and `cpu_pc`, so a breakpoint stops the CPU before the matching instruction.
- All other outputs are registered; `state`/`halt_cause` update one cycle after the deciding event.
- `start` to first `cpu_en` = 1: 1 cycle.
- `run_max` = N: exactly N enabled cycles, then HALT.
- `trace_data` reflects a push on the following cycle; pop latency is 0 (FWFT).
- `start` and `step` in the same cycle: treated as one start.

## Structure
- Package `cpu_dbg_pkg` holds:
  - state encoding (RST_HOLD/IDLE/RUN/HALT);
  - halt-cause codes;
  - mode codes.
- Sub-module `trace_fifo`: parametrised `PC_W` × `TRACE_DEPTH` overwrite-on-full FWFT FIFO with sticky overflow.
- FSM, counters and breakpoint compare live in `cpu_run_ctrl`.

## Test plan
- Reset, `RST_CYCLES` = 4: `cpu_rst` is high for 4 cycles after `rst` falls, then `state` = IDLE and all other outputs are at their reset values.
- Mode 0, `run_max` = 10, `cpu_pc` incrementing by 4 from 0x0: exactly 10 enabled cycles, then HALT with cause 1 and `cycle_cnt` = 10; trace holds 0x0..0x24 with `trace_ovf` = 0.
- Mode 2, bp0 = 0x20 enabled: `cpu_en` drops in the cycle `cpu_pc` = 0x20, HALT with cause 2. `start` then gives one enabled cycle at 0x20 with no re-halt, and execution continues.
- Mode 1: three `step` pulses give three enabled cycles, each followed by HALT with cause 3; `cycle_cnt` = 3.
- Trace, `TRACE_DEPTH` = 16: 20 pushes with no pops leave the oldest entry as the 5th PC and set `trace_ovf`. Simultaneous push and pop at full: count stays 16, no further effect on `trace_ovf`.
- `rst` asserted mid-RUN at `cycle_cnt` = 7: next cycle `state` = RST_HOLD, `cpu_en` = 0, `cycle_cnt` = 0, trace empty.
